// File: rtl/wb_commit_unit.sv
// Writeback commit queue: buffers completed instructions, drains them in order to the RF
// write port, and commits exceptions/interrupts. Optional retire counter under WB_MINSTRET_EN.
module wb_commit_unit #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   parameter int RA_W  = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            wb_valid_i,
   output logic            wb_ready_o,
   input  logic [RA_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            wb_we_i,
   input  logic            wb_trap_i,
   input  logic [3:0]      wb_trap_code_i,
   input  logic            rf_ready_i,
   output logic            rf_we_o,
   output logic [RA_W-1:0] rf_rd_o,
   output logic [XLEN-1:0] rf_data_o,
   input  logic            int_meip_i,
   input  logic            int_msip_i,
   input  logic            int_mtip_i,
   input  logic            mie_i,
   output logic            trap_o,
   output logic [4:0]      trap_cause_o,
   output logic [63:0]     minstret_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [3:0] CAUSE_MEI = 4'd11;
   localparam logic [3:0] CAUSE_MSI = 4'd3;
   localparam logic [3:0] CAUSE_MTI = 4'd7;

   logic [PW-1:0]   head_reg, head_next;
   logic [PW-1:0]   tail_reg, tail_next;
   logic [CW-1:0]   count_reg, count_next;

   logic [RA_W-1:0] rd_mem   [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];
   logic            we_mem   [DEPTH];
   logic            trap_mem [DEPTH];
   logic [3:0]      code_mem [DEPTH];

   logic            full;
   logic            head_valid;
   logic [RA_W-1:0] head_rd;
   logic [XLEN-1:0] head_data;
   logic            head_we;
   logic            head_trap;
   logic [3:0]      head_code;
   logic            head_writes;
   logic            pop;
   logic            flush;
   logic            push;
   logic            irq_req;
   logic            irq_take;
   logic [3:0]      irq_code;

   assign full       = (count_reg == CW'(DEPTH));
   assign head_valid = (count_reg != '0);

   assign head_rd   = rd_mem[head_reg];
   assign head_data = data_mem[head_reg];
   assign head_we   = we_mem[head_reg];
   assign head_trap = trap_mem[head_reg];
   assign head_code = code_mem[head_reg];

   // Only real register writes wait on the RF port; x0 writes and traps retire freely.
   assign head_writes = head_valid && head_we && (head_rd != '0) && !head_trap;
   assign pop         = !rst_i && head_valid && (rf_ready_i || !head_writes);
   assign flush       = pop && head_trap;

   // Interrupts are only taken on an empty queue, so they can never collide with a head trap.
   assign irq_req  = mie_i && (int_meip_i || int_msip_i || int_mtip_i);
   assign irq_take = !rst_i && irq_req && !head_valid;

   always_comb begin
      irq_code = CAUSE_MTI;
      if (int_meip_i) begin
         irq_code = CAUSE_MEI;
      end else if (int_msip_i) begin
         irq_code = CAUSE_MSI;
      end
   end

   assign wb_ready_o = !full && !irq_take;
   assign push       = wb_valid_i && wb_ready_o && !rst_i;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
         always_ff @(posedge clk_i) begin
            if (push && (tail_reg == PW'(gi))) begin
               rd_mem[gi]   <= wb_rd_i;
               data_mem[gi] <= wb_data_i;
               we_mem[gi]   <= wb_we_i;
               trap_mem[gi] <= wb_trap_i;
               code_mem[gi] <= wb_trap_code_i;
            end
         end
      end
   endgenerate

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush) begin
         // A committing trap discards everything, including a same-cycle push.
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (pop) begin
            head_next = head_reg + PW'(1);
         end
         if (push) begin
            tail_next = tail_reg + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      rf_we_o      = !rst_i && head_writes && rf_ready_i;
      rf_rd_o      = head_rd;
      rf_data_o    = head_data;
      trap_o       = 1'b0;
      trap_cause_o = 5'd0;
      if (flush) begin
         trap_o       = 1'b1;
         trap_cause_o = {1'b0, head_code};
      end else if (irq_take) begin
         trap_o       = 1'b1;
         trap_cause_o = {1'b1, irq_code};
      end
   end

`ifdef WB_MINSTRET_EN
   logic [63:0] minstret_reg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         minstret_reg <= '0;
      end else if (pop && !head_trap) begin
         minstret_reg <= minstret_reg + 64'd1;
      end
   end

   assign minstret_o = minstret_reg;
`else
   assign minstret_o = 64'd0;
`endif

endmodule

// File: doc/wb_commit_unit.md
WB_COMMIT_UNIT -- requirements
Module: wb_commit_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning commit-queue entries (power of two, >=2).
REQ-003 The block SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-004 clk_i  in  1  single clock; all state changes on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 wb_valid_i  in  1  MEM presents a completed instruction.
REQ-007 wb_ready_o  out  1  queue can accept this cycle.
REQ-008 wb_rd_i  in  RA_W  destination register.
REQ-009 wb_data_i  in  XLEN  writeback data.
REQ-010 wb_we_i  in  1  instruction writes the RF.
REQ-011 wb_trap_i  in  1  instruction raised an exception.
REQ-012 wb_trap_code_i  in  4  exception cause.
REQ-013 rf_ready_i  in  1  RF write port available.
REQ-014 rf_we_o / rf_rd_o / rf_data_o  out  1/RA_W/XLEN  RF write port.
REQ-015 int_meip_i, int_msip_i, int_mtip_i  in  1 each  level interrupt requests.
REQ-016 mie_i  in  1  global interrupt enable.
REQ-017 trap_o  out  1  one-cycle trap/interrupt commit pulse to hazard unit and CSR.
REQ-018 trap_cause_o  out  5  {interrupt flag, 4-bit code}, valid with trap_o.
REQ-019 minstret_o  out  64  retired-instruction count (see Configuration).

Function
REQ-020 Push SHALL occur when wb_valid_i && wb_ready_o; wb_ready_o = !full && !irq_take.
REQ-021 Full SHALL mean DEPTH occupied entries; push while full is impossible (no bypass); simultaneous push and pop at full SHALL not accept.
REQ-022 Minimum latency SHALL be one cycle: entry pushed in cycle N appears on the RF port no earlier than N+1.
REQ-023 Head entry SHALL retire when valid and (rf_ready_i or head does not write the RF).
REQ-024 rf_we_o SHALL equal head_valid && head_we && head_rd != 0 && !head_trap && rf_ready_i; rf_rd_o/rf_data_o carry head fields.
REQ-025 A head entry with trap set SHALL retire without RF write, assert trap_o for that cycle with trap_cause_o = {0, code}, and flush all queue entries, including any pushed in the same cycle.
REQ-026 Interrupts: irq_take SHALL be asserted when mie_i and any int_* is high and the queue is empty; priority MEI > MSI > MTI, causes 11, 3, 7 respectively.
REQ-027 On irq_take, trap_o SHALL pulse with trap_cause_o = {1, code} and wb_ready_o SHALL be low that cycle.
REQ-028 Pointers SHALL wrap modulo DEPTH; occupancy count SHALL range 0..DEPTH.
REQ-029 trap_o SHALL never pulse twice in one cycle; exception at head takes precedence (queue non-empty precludes irq_take).

Reset
REQ-030 On rst_i high at a clock edge: queue empty, pointers 0, wb_ready_o = 1 after reset, rf_we_o = 0, trap_o = 0, trap_cause_o = 0, minstret_o = 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries with no RF write or trap pulse in the reset cycle.

Configuration
REQ-032 Macro WB_MINSTRET_EN defined: minstret_o SHALL increment by 1 per retired non-trap entry, wrapping at 2^64.
REQ-033 Macro WB_MINSTRET_EN undefined: counter SHALL not be implemented and minstret_o SHALL be constant 0.

Verification
REQ-034 Push rd=5,data=0xDEADBEEF,we=1 with rf_ready_i=1 -> next cycle rf_we_o=1, rf_rd_o=5, rf_data_o=0xDEADBEEF; minstret_o=1.
REQ-035 rf_ready_i=0, push 4 entries -> wb_ready_o=0 after the 4th; raise rf_ready_i -> 4 writes in order, one per cycle.
REQ-036 Push rd=0,we=1 -> no rf_we_o, entry retires, minstret_o increments.
REQ-037 Queue holds entry, trap entry (code 2), entry -> first writes, then trap_o=1 with cause 0x02, third entry flushed, no write.
REQ-038 Queue empty, mie_i=1, int_mtip_i=int_msip_i=1 -> trap_o=1, trap_cause_o=0x13, wb_ready_o=0 that cycle.
REQ-039 rst_i pulsed with 3 queued entries -> no further RF writes, all outputs at reset values next cycle.
